// File: rtl/soul_renderer_pkg.sv
// Shared types and constants for the soul renderer: FSM states, palette and
// the default battle-box geometry.
package soul_renderer_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } soul_state_t;

  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;

  localparam int DEF_BOX_X0    = 200;
  localparam int DEF_BOX_Y0    = 240;
  localparam int DEF_BOX_X1    = 439;
  localparam int DEF_BOX_Y1    = 399;
  localparam int DEF_BORDER    = 4;
  localparam int DEF_SOUL_SIZE = 16;

endpackage

// File: rtl/soul_sprite_rom.sv
// 16x16 1-bit heart bitmap; column 0 is the leftmost pixel (MSB of each row).
module soul_sprite_rom (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       pixel
);

  logic [15:0] row_bits;

  always_comb begin
    // NOTE: every combinational output gets a value on every path (here via
    // the default arm) so no latch is inferred.
    case (row)
      4'd1:    row_bits = 16'h3C3C;
      4'd2:    row_bits = 16'h7E7E;
      4'd3:    row_bits = 16'hFFFF;
      4'd4:    row_bits = 16'hFFFF;
      4'd5:    row_bits = 16'hFFFF;
      4'd6:    row_bits = 16'hFFFF;
      4'd7:    row_bits = 16'h7FFE;
      4'd8:    row_bits = 16'h3FFC;
      4'd9:    row_bits = 16'h1FF8;
      4'd10:   row_bits = 16'h0FF0;
      4'd11:   row_bits = 16'h07E0;
      4'd12:   row_bits = 16'h03C0;
      4'd13:   row_bits = 16'h0180;
      default: row_bits = 16'h0000;
    endcase
    pixel = row_bits[4'd15 - col];
  end

endmodule

// File: rtl/soul_renderer.sv
// Player soul: button-driven movement inside the battle box, HP / i-frame FSM,
// and a registered pixel layer drawing the soul sprite over the box border.
module soul_renderer
  import soul_renderer_pkg::*;
#(
  parameter int BOX_X0    = DEF_BOX_X0,
  parameter int BOX_Y0    = DEF_BOX_Y0,
  parameter int BOX_X1    = DEF_BOX_X1,
  parameter int BOX_Y1    = DEF_BOX_Y1,
  parameter int BORDER    = DEF_BORDER,
  parameter int SOUL_SIZE = DEF_SOUL_SIZE,
  parameter int STEP      = 2,
  parameter int HP_MAX    = 20,
  parameter int DMG       = 4,
  parameter int IFRAMES   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pix_stb,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        animate,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        hit,
  input  logic        restart,
  output logic [11:0] rgb,
  output logic [15:0] soul_x,
  output logic [15:0] soul_y,
  output logic [7:0]  hp,
  output logic        dead
);

  localparam logic [15:0] XMIN  = 16'(BOX_X0 + BORDER);
  localparam logic [15:0] XMAX  = 16'(BOX_X1 - BORDER - SOUL_SIZE + 1);
  localparam logic [15:0] YMIN  = 16'(BOX_Y0 + BORDER);
  localparam logic [15:0] YMAX  = 16'(BOX_Y1 - BORDER - SOUL_SIZE + 1);
  localparam logic [15:0] XC    = 16'((BOX_X0 + BORDER + BOX_X1 - BORDER - SOUL_SIZE + 1) / 2);
  localparam logic [15:0] YC    = 16'((BOX_Y0 + BORDER + BOX_Y1 - BORDER - SOUL_SIZE + 1) / 2);
  localparam logic [15:0] STP   = 16'(STEP);
  localparam logic [15:0] SZ    = 16'(SOUL_SIZE);
  localparam logic [15:0] IFR0  = 16'(IFRAMES);
  localparam logic [7:0]  HP0   = 8'(HP_MAX);
  localparam logic [7:0]  DMG8  = 8'(DMG);
  localparam logic [15:0] OX0   = 16'(BOX_X0);
  localparam logic [15:0] OY0   = 16'(BOX_Y0);
  localparam logic [15:0] OX1   = 16'(BOX_X1);
  localparam logic [15:0] OY1   = 16'(BOX_Y1);
  localparam logic [15:0] IX0   = 16'(BOX_X0 + BORDER);
  localparam logic [15:0] IY0   = 16'(BOX_Y0 + BORDER);
  localparam logic [15:0] IX1   = 16'(BOX_X1 - BORDER);
  localparam logic [15:0] IY1   = 16'(BOX_Y1 - BORDER);

  soul_state_t state;
  logic [15:0] iframe_cnt;
  logic        tick;
  logic [15:0] next_x, next_y;
  logic [7:0]  hp_hit;

  // animate spans several clk cycles; the pixel strobe picks exactly one of them.
  assign tick   = animate & i_pix_stb;
  assign hp_hit = (hp > DMG8) ? hp - DMG8 : 8'd0;

  // Saturating moves: compare against the bound before stepping so nothing wraps.
  always_comb begin
    next_x = soul_x;
    next_y = soul_y;
    if (btn_left && !btn_right)
      next_x = (soul_x >= XMIN + STP) ? soul_x - STP : XMIN;
    else if (btn_right && !btn_left)
      next_x = (soul_x >= XMAX - STP) ? XMAX : soul_x + STP;
    if (btn_up && !btn_down)
      next_y = (soul_y >= YMIN + STP) ? soul_y - STP : YMIN;
    else if (btn_down && !btn_up)
      next_y = (soul_y >= YMAX - STP) ? YMAX : soul_y + STP;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset || restart) begin
      state      <= ALIVE;
      hp         <= HP0;
      iframe_cnt <= '0;
      soul_x     <= XC;
      soul_y     <= YC;
      dead       <= 1'b0;
    end else begin
      case (state)
        ALIVE: begin
          if (tick) begin
            soul_x <= next_x;
            soul_y <= next_y;
          end
          if (hit) begin
            hp <= hp_hit;
            if (hp_hit == 8'd0) begin
              state <= DEAD;
              dead  <= 1'b1;
            end else begin
              state      <= INVULN;
              iframe_cnt <= IFR0;
            end
          end
        end
        INVULN: begin
          if (tick) begin
            soul_x <= next_x;
            soul_y <= next_y;
            if (iframe_cnt == 16'd1) begin
              state      <= ALIVE;
              iframe_cnt <= '0;
            end else begin
              iframe_cnt <= iframe_cnt - 16'd1;
            end
          end
        end
        DEAD: ;
        default: state <= ALIVE;
      endcase
    end
  end

  logic [15:0] dx, dy;
  logic        in_soul, visible, sprite_bit, in_outer, in_inner;

  // Unsigned differences: pixels left of / above the soul wrap to large values.
  assign dx       = x - soul_x;
  assign dy       = y - soul_y;
  assign in_soul  = (dx < SZ) && (dy < SZ);
  assign visible  = (state == ALIVE) || ((state == INVULN) && !iframe_cnt[2]);
  assign in_outer = (x >= OX0) && (x <= OX1) && (y >= OY0) && (y <= OY1);
  assign in_inner = (x >= IX0) && (x <= IX1) && (y >= IY0) && (y <= IY1);

  soul_sprite_rom u_sprite (
    .row   (dy[3:0]),
    .col   (dx[3:0]),
    .pixel (sprite_bit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      rgb <= BLACK;
    else if (visible && in_soul && sprite_bit)
      rgb <= RED;
    else if (in_outer && !in_inner)
      rgb <= WHITE;
    else
      rgb <= BLACK;
  end

endmodule

// File: tb/tb_soul_renderer.sv
// Scoreboard bench for soul_renderer: a rule-level model predicts each probed
// cycle, and a monitor compares the DUT outputs one clk later.
module tb_soul_renderer;

  localparam int BX0 = 200, BY0 = 240, BX1 = 439, BY1 = 399, BRD = 4, SZ = 16;
  localparam int XMIN = BX0 + BRD, XMAX = BX1 - BRD - SZ + 1;
  localparam int YMIN = BY0 + BRD, YMAX = BY1 - BRD - SZ + 1;
  localparam int XC = (XMIN + XMAX) / 2, YC = (YMIN + YMAX) / 2;
  localparam int M_ALIVE = 0, M_INVULN = 1, M_DEAD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, i_pix_stb, animate, hit, restart;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [15:0] x, y;
  logic [11:0] rgb;
  logic [15:0] soul_x, soul_y;
  logic [7:0]  hp;
  logic        dead;

  soul_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .i_pix_stb (i_pix_stb),
    .x         (x),
    .y         (y),
    .animate   (animate),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .hit       (hit),
    .restart   (restart),
    .rgb       (rgb),
    .soul_x    (soul_x),
    .soul_y    (soul_y),
    .hp        (hp),
    .dead      (dead)
  );

  typedef struct {
    logic [11:0] rgb;
    int          hp;
    int          sx;
    int          sy;
    bit          dead;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  logic probe = 1'b0;

  int m_st, m_hp, m_sx, m_sy, m_ifr;

  logic [15:0] heart [16] = '{16'h0000, 16'h3C3C, 16'h7E7E, 16'hFFFF,
                              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFE,
                              16'h3FFC, 16'h1FF8, 16'h0FF0, 16'h07E0,
                              16'h03C0, 16'h0180, 16'h0000, 16'h0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] model_pixel(input int px, input int py);
    bit          vis, in_soul, outer, inner;
    logic [15:0] rowv;
    vis     = (m_st == M_ALIVE) || (m_st == M_INVULN && m_ifr[2] == 1'b0);
    in_soul = px >= m_sx && px < m_sx + SZ && py >= m_sy && py < m_sy + SZ;
    if (vis && in_soul) begin
      rowv = heart[py - m_sy];
      if (rowv[15 - (px - m_sx)]) return 12'hF00;
    end
    outer = px >= BX0 && px <= BX1 && py >= BY0 && py <= BY1;
    inner = px >= BX0 + BRD && px <= BX1 - BRD && py >= BY0 + BRD && py <= BY1 - BRD;
    return (outer && !inner) ? 12'hFFF : 12'h000;
  endfunction

  // Predict the effect of the coming clk edge, queue it if probed, then advance.
  task automatic cycle(input bit prb);
    exp_t e;
    bit   tk;
    e.rgb = reset ? 12'h000 : model_pixel(int'(x), int'(y));
    tk = animate && i_pix_stb;
    if (reset || restart) begin
      m_st = M_ALIVE; m_hp = 20; m_ifr = 0; m_sx = XC; m_sy = YC;
    end else if (m_st != M_DEAD) begin
      if (tk) begin
        if (btn_left && !btn_right) m_sx = (m_sx - 2 < XMIN) ? XMIN : m_sx - 2;
        if (btn_right && !btn_left) m_sx = (m_sx + 2 > XMAX) ? XMAX : m_sx + 2;
        if (btn_up && !btn_down)    m_sy = (m_sy - 2 < YMIN) ? YMIN : m_sy - 2;
        if (btn_down && !btn_up)    m_sy = (m_sy + 2 > YMAX) ? YMAX : m_sy + 2;
      end
      if (m_st == M_ALIVE && hit) begin
        m_hp = (m_hp - 4 < 0) ? 0 : m_hp - 4;
        if (m_hp == 0) m_st = M_DEAD;
        else begin m_st = M_INVULN; m_ifr = 60; end
      end else if (m_st == M_INVULN && tk) begin
        m_ifr--;
        if (m_ifr == 0) m_st = M_ALIVE;
      end
    end
    e.hp = m_hp; e.sx = m_sx; e.sy = m_sy; e.dead = (m_st == M_DEAD);
    probe = prb;
    if (prb) sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic aim_soul();
    x = 16'(m_sx + 8);
    y = 16'(m_sy + 8);
  endtask

  task automatic frame(input bit h);
    aim_soul();
    hit = h; animate = 1'b1; i_pix_stb = 1'b1;
    cycle(1'b1);
    hit = 1'b0; animate = 1'b0; i_pix_stb = 1'b0;
    aim_soul();
    cycle(1'b1);
  endtask

  task automatic buttons(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic probe_at(input int px, input int py);
    x = 16'(px); y = 16'(py);
    cycle(1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (probe) begin
        #1;
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_underflow at %0t: got 0 entries expected 1", $time);
        end else begin
          e = sb_q.pop_front();
          check("rgb",    32'(rgb),    32'(e.rgb));
          check("hp",     32'(hp),     32'(e.hp));
          check("soul_x", 32'(soul_x), 32'(e.sx));
          check("soul_y", 32'(soul_y), 32'(e.sy));
          check("dead",   32'(dead),   32'(e.dead));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; restart = 1'b0; hit = 1'b0; animate = 1'b0; i_pix_stb = 1'b0;
    buttons(0, 0, 0, 0);
    x = 16'd0; y = 16'd0;
    m_st = M_ALIVE; m_hp = 20; m_ifr = 0; m_sx = XC; m_sy = YC;
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;

    // Left wall: saturate at XMIN, then opposing buttons cancel.
    buttons(0, 0, 1, 0);
    repeat (200) frame(1'b0);
    buttons(0, 0, 1, 1);
    repeat (5) frame(1'b0);

    // Long animate pulse, strobe only on its last cycle: one step per frame.
    buttons(0, 1, 0, 0);
    for (int f = 0; f < 8; f++) begin
      animate = 1'b1;
      for (int c = 0; c < 4; c++) begin
        i_pix_stb = (c == 3);
        aim_soul();
        cycle(1'b1);
      end
      animate = 1'b0; i_pix_stb = 1'b0;
      cycle(1'b1);
    end
    buttons(0, 0, 0, 0);

    // One hit, then repeated hits ignored through the blinking i-frames.
    frame(1'b1);
    for (int f = 0; f < 65; f++) frame(f < 10);

    // Drain HP to zero with spaced hits; dead soul ignores movement.
    for (int h = 0; h < 5; h++) begin
      frame(1'b1);
      repeat (61) frame(1'b0);
    end
    buttons(1, 0, 0, 0);
    repeat (3) frame(1'b0);
    buttons(0, 0, 0, 0);
    restart = 1'b1; hit = 1'b1; animate = 1'b1; i_pix_stb = 1'b1;
    cycle(1'b1);
    restart = 1'b0; hit = 1'b0; animate = 1'b0; i_pix_stb = 1'b0;
    cycle(1'b1);

    // Pixel sweep across box corners, inner edges and the soul.
    probe_at(BX0, BY0);
    probe_at(BX0 + BRD, BY0 + BRD);
    probe_at(BX0 + BRD - 1, BY0 + 100);
    probe_at(BX1, BY1);
    probe_at(BX1 + 1, BY1);
    probe_at(BX1 - BRD, BY1 - BRD);
    probe_at(XC + 8, YC + 8);
    probe_at(XC, YC);
    probe_at(XC + 2, YC + 1);

    // Reset halfway through the i-frames.
    frame(1'b1);
    repeat (30) frame(1'b0);
    aim_soul();
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    repeat (3) frame(1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      buttons($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      animate   = ($urandom_range(0, 2) == 0);
      i_pix_stb = ($urandom_range(0, 1) == 0);
      hit       = ($urandom_range(0, 15) == 0);
      restart   = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 0) begin
        x = 16'(m_sx + int'($urandom_range(0, 17)) - 1);
        y = 16'(m_sy + int'($urandom_range(0, 17)) - 1);
      end else begin
        x = 16'($urandom_range(195, 445));
        y = 16'($urandom_range(235, 405));
      end
      cycle(1'b1);
    end
    reset = 1'b0; restart = 1'b0; hit = 1'b0; animate = 1'b0; i_pix_stb = 1'b0;

    cycle(1'b0);
    cycle(1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soul_renderer.md
SOUL_RENDERER -- requirements
Module: soul_renderer

Interface
REQ-001 SHALL have parameters: BOX_X0=200, BOX_Y0=240, BOX_X1=439, BOX_Y1=399 (battle box outer corners, inclusive); BORDER=4 (box border thickness, px); SOUL_SIZE=16 (soul sprite edge, px); STEP=2 (px moved per frame); HP_MAX=20 (starting HP); DMG=4 (HP lost per hit); IFRAMES=60 (invulnerability length, frames).
REQ-002 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising clk edge.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 i_pix_stb  input  1  pixel strobe from the timing generator.
REQ-006 x, y  input  16 each  current active pixel coordinate from the timing generator.
REQ-007 animate  input  1  end-of-active-frame flag from the timing generator; may stay high for several clk cycles.
REQ-008 btn_up, btn_down, btn_left, btn_right  input  1 each  synchronized, debounced button levels.
REQ-009 hit  input  1  collision pulse from the bullet layer; any width.
REQ-010 restart  input  1  restart request.
REQ-011 rgb  output  12  registered 4:4:4 pixel colour, {R,G,B}.
REQ-012 soul_x, soul_y  output  16 each  top-left corner of the soul.
REQ-013 hp  output  8  current HP.
REQ-014 dead  output  1  high while in DEAD.

Function
REQ-015 SHALL derive tick = animate & i_pix_stb, so tick lasts exactly one clk cycle per frame.
REQ-016 SHALL bound the soul to XMIN=BOX_X0+BORDER, XMAX=BOX_X1-BORDER-SOUL_SIZE+1, YMIN=BOX_Y0+BORDER and YMAX=BOX_Y1-BORDER-SOUL_SIZE+1.
REQ-017 On tick, outside DEAD: up-only SHALL set soul_y=max(soul_y-STEP,YMIN); down-only SHALL set soul_y=min(soul_y+STEP,YMAX); up+down together or neither SHALL leave soul_y unchanged; left/right SHALL act on soul_x the same way; arithmetic SHALL saturate and never wrap.
REQ-018 The FSM SHALL have states ALIVE, INVULN and DEAD.
REQ-019 ALIVE & hit -> hp=sat(hp-DMG), floored at 0; if the result is 0 -> DEAD, else -> INVULN with iframe_cnt=IFRAMES.
REQ-020 In INVULN, hit SHALL be ignored; on each tick iframe_cnt SHALL decrement; tick while iframe_cnt==1 -> ALIVE.
REQ-021 In DEAD, position SHALL freeze, dead=1, and hit and tick SHALL be ignored.
REQ-022 restart in any state SHALL force ALIVE, hp=HP_MAX, iframe_cnt=0 and the soul to centre (XC=(XMIN+XMAX)/2, YC=(YMIN+YMAX)/2); restart SHALL take priority over simultaneous hit and tick.
REQ-023 A simultaneous hit and tick in ALIVE SHALL apply both: the position moves and the hit transitions state in the same cycle.
REQ-024 Soul visibility SHALL be: ALIVE visible; INVULN visible only when iframe_cnt[2]==0 (blink); DEAD invisible.
REQ-025 rgb SHALL be registered with 1 clk latency from x,y, priority highest first:
  - visible soul pixel with sprite bit 1 -> 12'hF00;
  - box border ring -> 12'hFFF;
  - otherwise -> 12'h000.
REQ-026 rgb SHALL not perform blanking; the top level gates it.
REQ-027 hp SHALL never exceed HP_MAX nor underflow below 0.

Reset
REQ-028 reset SHALL take effect on the next clk edge and has priority over restart; it SHALL set state=ALIVE, hp=HP_MAX, iframe_cnt=0, soul_x=XC, soul_y=YC, rgb=12'h000, dead=0.
REQ-029 reset asserted mid-INVULN or mid-frame SHALL abandon all in-progress counts with no residual blink.

Structure
REQ-030 A shared package SHALL hold the state enum (ALIVE/INVULN/DEAD), the colour constants (RED, WHITE, BLACK) and the default box geometry.
REQ-031 A sub-module soul_sprite_rom SHALL provide a 16x16 1-bit heart bitmap, combinational, indexed by (y-soul_y, x-soul_x).

Verification
REQ-032 Reset, then hold btn_left for 200 ticks -> soul_x==XMIN=204 with no wrap; add btn_right held simultaneously -> soul_x stays 204.
REQ-033 animate held high for 4 clk cycles with i_pix_stb every 4th cycle -> exactly one STEP move per frame.
REQ-034 One hit in ALIVE -> hp=16, INVULN; 10 more hits within 60 ticks -> hp stays 16; after 60 ticks -> ALIVE; soul pixel at rgb toggles with iframe_cnt[2].
REQ-035 Five hits spaced >60 ticks apart -> hp=0 with no underflow, dead=1; tick with btn_up -> soul_y unchanged; restart+hit in the same cycle -> hp=20, ALIVE, soul at (XC,YC).
REQ-036 Pixel sweep: (BOX_X0,BOX_Y0) -> 12'hFFF; (BOX_X0+BORDER,BOX_Y0+BORDER) away from the soul -> 12'h000; a soul sprite-1 pixel -> 12'hF00; each appears one clk after x,y are presented.
REQ-037 reset asserted in INVULN with iframe_cnt=30 -> the next cycle shows ALIVE, hp=20, rgb=0, and the soul visible on the following frame.
